rom_port_arbiter: RTL and testbench

- Shares one toggle-handshake SDRAM port between three requesters: the ROM download writer, the CPU byte fetch and the graphics word fetch.
- Sits between data_io/core logic and the sdram controller, all in the clock_48 domain.
- Holds a one-word CPU fetch cache, so repeated even/odd byte reads of the same word skip SDRAM.
- Round-robins between the CPU and graphics requesters; download writes always win.

---
 rtl/rom_arb_pkg.sv | 14 +
 rtl/rom_word_cache.sv | 47 ++++
 rtl/rom_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the ROM/CPU/GFX SDRAM port arbiter.
package rom_arb_pkg;

    localparam int WA = 23;
    localparam int WD = 16;

    typedef enum logic [1:0] {SYNC, IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {GNT_DL, GNT_CPU, GNT_GFX} grant_t;

    function automatic logic [7:0] byte_sel(input logic [WD-1:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/rom_word_cache.sv
// One-word read cache for CPU byte fetches; invalidate wins over a same-cycle fill.
module rom_word_cache
    import rom_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          fill,
    input  logic          inval,
    input  logic [14:0]   fill_tag,
    input  logic [WD-1:0] fill_data,
    input  logic [14:0]   look_tag,
    output logic          hit,
    output logic [WD-1:0] data
);

    logic          valid_q, valid_d;
    logic [14:0]   tag_q, tag_d;
    logic [WD-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end
        if (inval) valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && (tag_q == look_tag);
    assign data = data_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates ROM download writes, CPU byte reads and GFX word reads onto one
// toggle-handshake SDRAM port. Ack/data are registered before use by the FSM.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [WA-1:0] CPU_BASE = 23'h000000,
    parameter logic [WA-1:0] GFX_BASE = 23'h008000
) (
    input  logic          clock_48,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [23:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_overrun,
    input  logic          cpu_req,
    input  logic [15:0]   cpu_addr,
    output logic [7:0]    cpu_dout,
    output logic          cpu_valid,
    input  logic          gfx_req,
    input  logic [15:0]   gfx_addr,
    output logic [WD-1:0] gfx_dout,
    output logic          gfx_valid,
    output logic          port_req,
    input  logic          port_ack,
    output logic [WA-1:0] port_a,
    output logic [1:0]    port_ds,
    output logic          port_we,
    output logic [WD-1:0] port_d,
    input  logic [WD-1:0] port_q,
    output logic          busy
);

    state_t        state_q, state_d;
    grant_t        grant_q, grant_d, sel, rsp_grant;
    logic          issue, readers_ok, sync_ok;
    logic          ack_q, dl_active_q;
    logic [WD-1:0] q_q, rsp_word;

    logic          dl_pend_q, dl_pend_d, cpu_pend_q, cpu_pend_d, gfx_pend_q, gfx_pend_d;
    logic [23:0]   dl_addr_q, dl_addr_d;
    logic [7:0]    dl_data_q, dl_data_d;
    logic [15:0]   cpu_addr_q, cpu_addr_d, gfx_addr_q, gfx_addr_d;
    logic          dl_overrun_q, dl_overrun_d, last_grant_q, last_grant_d;
    logic          clr_dl, clr_cpu, clr_gfx;

    logic          port_req_q, port_req_d, port_we_q, port_we_d;
    logic [WA-1:0] port_a_q, port_a_d;
    logic [1:0]    port_ds_q, port_ds_d;
    logic [WD-1:0] port_d_q, port_d_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic          cpu_valid_q, cpu_valid_d, gfx_valid_q, gfx_valid_d, busy_q, busy_d;
    logic [WD-1:0] gfx_dout_q, gfx_dout_d;

    logic          cache_fill, cache_inval, cache_hit;
    logic [WD-1:0] cache_data;

    rom_word_cache u_cache (
        .clk       (clock_48),
        .rst       (reset),
        .fill      (cache_fill),
        .inval     (cache_inval),
        .fill_tag  (cpu_addr_q[15:1]),
        .fill_data (q_q),
        .look_tag  (cpu_addr_q[15:1]),
        .hit       (cache_hit),
        .data      (cache_data)
    );

    // Readers are held for one extra cycle after dl_active falls so the
    // falling-edge invalidate lands before any hit check.
    assign readers_ok = !dl_active && !dl_active_q;
    assign sync_ok    = (ack_q == port_req_q);

    always_comb begin
        dl_pend_d    = dl_pend_q & ~clr_dl;
        cpu_pend_d   = cpu_pend_q & ~clr_cpu;
        gfx_pend_d   = gfx_pend_q & ~clr_gfx;
        dl_addr_d    = dl_addr_q;
        dl_data_d    = dl_data_q;
        cpu_addr_d   = cpu_addr_q;
        gfx_addr_d   = gfx_addr_q;
        dl_overrun_d = dl_overrun_q;
        if (dl_wr) begin
            if (dl_pend_q) begin
                dl_overrun_d = 1'b1;
            end else begin
                dl_pend_d = 1'b1;
                dl_addr_d = dl_addr;
                dl_data_d = dl_data;
            end
        end
        if (cpu_req && !cpu_pend_q) begin
            cpu_pend_d = 1'b1;
            cpu_addr_d = cpu_addr;
        end
        if (gfx_req && !gfx_pend_q) begin
            gfx_pend_d = 1'b1;
            gfx_addr_d = gfx_addr;
        end
    end

    always_comb begin
        sel   = GNT_DL;
        issue = 1'b0;
        if (dl_pend_q) begin
            sel   = GNT_DL;
            issue = 1'b1;
        end else if (readers_ok && cpu_pend_q && gfx_pend_q) begin
            sel   = last_grant_q ? GNT_CPU : GNT_GFX;
            issue = 1'b1;
        end else if (readers_ok && cpu_pend_q) begin
            sel   = GNT_CPU;
            issue = 1'b1;
        end else if (readers_ok && gfx_pend_q) begin
            sel   = GNT_GFX;
            issue = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            SYNC: if (sync_ok) state_d = IDLE;
            // A stray ack (e.g. from an access cut short by reset) sends us back to SYNC.
            IDLE: begin
                if (!sync_ok)   state_d = SYNC;
                else if (issue) state_d = (sel == GNT_CPU && cache_hit) ? RESP : WAIT;
            end
            WAIT: if (sync_ok) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        grant_d      = grant_q;
        port_req_d   = port_req_q;
        port_a_d     = port_a_q;
        port_ds_d    = port_ds_q;
        port_we_d    = port_we_q;
        port_d_d     = port_d_q;
        cpu_dout_d   = cpu_dout_q;
        cpu_valid_d  = 1'b0;
        gfx_dout_d   = gfx_dout_q;
        gfx_valid_d  = 1'b0;
        last_grant_d = last_grant_q;
        clr_dl       = 1'b0;
        clr_cpu      = 1'b0;
        clr_gfx      = 1'b0;
        cache_fill   = 1'b0;
        cache_inval  = dl_active_q & ~dl_active;
        busy_d       = (state_d != IDLE);
        rsp_grant    = (state_q == IDLE) ? sel : grant_q;
        rsp_word     = (state_q == IDLE) ? cache_data : q_q;

        if (state_q == IDLE && (state_d == WAIT || state_d == RESP)) grant_d = sel;

        if (state_q == IDLE && state_d == WAIT) begin
            port_req_d = ~port_req_q;
            case (sel)
                GNT_DL: begin
                    port_a_d    = dl_addr_q[23:1];
                    port_ds_d   = {dl_addr_q[0], ~dl_addr_q[0]};
                    port_d_d    = {dl_data_q, dl_data_q};
                    port_we_d   = 1'b1;
                    cache_inval = 1'b1;
                end
                GNT_CPU: begin
                    port_a_d  = CPU_BASE + {8'd0, cpu_addr_q[15:1]};
                    port_ds_d = 2'b11;
                    port_we_d = 1'b0;
                end
                GNT_GFX: begin
                    port_a_d  = GFX_BASE + {7'd0, gfx_addr_q};
                    port_ds_d = 2'b11;
                    port_we_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Results are registered on RESP entry so they are visible during RESP.
        if (state_d == RESP) begin
            case (rsp_grant)
                GNT_DL: clr_dl = 1'b1;
                GNT_CPU: begin
                    clr_cpu      = 1'b1;
                    cpu_valid_d  = 1'b1;
                    cpu_dout_d   = byte_sel(rsp_word, cpu_addr_q[0]);
                    cache_fill   = (state_q == WAIT);
                    last_grant_d = 1'b0;
                end
                GNT_GFX: begin
                    clr_gfx      = 1'b1;
                    gfx_valid_d  = 1'b1;
                    gfx_dout_d   = rsp_word;
                    last_grant_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_48 or posedge reset) begin
        if (reset) begin
            state_q      <= SYNC;
            grant_q      <= GNT_DL;
            ack_q        <= 1'b0;
            q_q          <= '0;
            dl_active_q  <= 1'b0;
            dl_pend_q    <= 1'b0;
            cpu_pend_q   <= 1'b0;
            gfx_pend_q   <= 1'b0;
            dl_addr_q    <= '0;
            dl_data_q    <= '0;
            cpu_addr_q   <= '0;
            gfx_addr_q   <= '0;
            dl_overrun_q <= 1'b0;
            last_grant_q <= 1'b0;
            port_req_q   <= 1'b0;
            port_a_q     <= '0;
            port_ds_q    <= '0;
            port_we_q    <= 1'b0;
            port_d_q     <= '0;
            cpu_dout_q   <= '0;
            cpu_valid_q  <= 1'b0;
            gfx_dout_q   <= '0;
            gfx_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ack_q        <= port_ack;
            q_q          <= port_q;
            dl_active_q  <= dl_active;
            dl_pend_q    <= dl_pend_d;
            cpu_pend_q   <= cpu_pend_d;
            gfx_pend_q   <= gfx_pend_d;
            dl_addr_q    <= dl_addr_d;
            dl_data_q    <= dl_data_d;
            cpu_addr_q   <= cpu_addr_d;
            gfx_addr_q   <= gfx_addr_d;
            dl_overrun_q <= dl_overrun_d;
            last_grant_q <= last_grant_d;
            port_req_q   <= port_req_d;
            port_a_q     <= port_a_d;
            port_ds_q    <= port_ds_d;
            port_we_q    <= port_we_d;
            port_d_q     <= port_d_d;
            cpu_dout_q   <= cpu_dout_d;
            cpu_valid_q  <= cpu_valid_d;
            gfx_dout_q   <= gfx_dout_d;
            gfx_valid_q  <= gfx_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign dl_overrun = dl_overrun_q;
    assign cpu_dout   = cpu_dout_q;
    assign cpu_valid  = cpu_valid_q;
    assign gfx_dout   = gfx_dout_q;
    assign gfx_valid  = gfx_valid_q;
    assign port_req   = port_req_q;
    assign port_a     = port_a_q;
    assign port_ds    = port_ds_q;
    assign port_we    = port_we_q;
    assign port_d     = port_d_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: expected port transactions and read
// responses are queued by the stimulus and checked by a negedge monitor.
module tb_rom_port_arbiter;

    typedef struct {
        logic [22:0] a;
        logic [1:0]  ds;
        logic        we;
        logic [15:0] d;
    } port_exp_t;

    typedef struct {
        logic [15:0] data;
        bit          rel_ack;
        int          due;
    } rd_exp_t;

    logic        clock_48 = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0, dl_wr = 1'b0;
    logic [23:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_overrun;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_valid;
    logic        gfx_req = 1'b0;
    logic [15:0] gfx_addr = '0;
    logic [15:0] gfx_dout;
    logic        gfx_valid;
    logic        port_req;
    logic        port_ack = 1'b0;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic        port_we;
    logic [15:0] port_d;
    logic [15:0] port_q = '0;
    logic        busy;

    rom_port_arbiter dut (
        .clock_48(clock_48), .reset(reset),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_overrun(dl_overrun),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_valid(cpu_valid),
        .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_dout(gfx_dout), .gfx_valid(gfx_valid),
        .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
        .port_we(port_we), .port_d(port_d), .port_q(port_q), .busy(busy)
    );

    always #5 clock_48 = ~clock_48;

    int cyc = 0;
    always @(posedge clock_48) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0, n_tog = 0;
    port_exp_t port_exp[$];
    rd_exp_t   cpu_exp[$];
    rd_exp_t   gfx_exp[$];
    logic [15:0] mem [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [22:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // SDRAM controller model: answers a toggle after lat cycles.
    bit   model_en = 1'b1, ack_ovr_en = 1'b0;
    logic ack_ovr_val = 1'b0;
    int   lat = 3, wcnt = 0, ack_cyc = 0;
    always @(negedge clock_48) begin
        if (ack_ovr_en) begin
            port_ack = ack_ovr_val;
        end else if (model_en && port_req !== port_ack) begin
            if (wcnt >= lat) begin
                if (!port_we) port_q = rd_word(port_a);
                port_ack = port_req;
                ack_cyc  = cyc;
                wcnt     = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    logic prev_req = 1'b0;
    always @(negedge clock_48) begin
        port_exp_t pe;
        rd_exp_t   re;
        if (!reset) begin
            if (port_req !== prev_req) begin
                n_tog++;
                if (port_exp.size() == 0) begin
                    chk("unexpected_port_req", 32'(port_a), 32'h7FFFFFFF);
                end else begin
                    pe = port_exp.pop_front();
                    chk("port_a", 32'(port_a), 32'(pe.a));
                    chk("port_ds", 32'(port_ds), 32'(pe.ds));
                    chk("port_we", 32'(port_we), 32'(pe.we));
                    if (pe.we) chk("port_d", 32'(port_d), 32'(pe.d));
                end
            end
            if (cpu_valid) begin
                if (cpu_exp.size() == 0) begin
                    chk("unexpected_cpu_valid", 32'(cpu_dout), 32'hFFFFFFFF);
                end else begin
                    re = cpu_exp.pop_front();
                    chk("cpu_dout", 32'(cpu_dout), 32'(re.data[7:0]));
                    chk("cpu_latency", 32'(cyc), 32'(re.rel_ack ? ack_cyc + 2 : re.due));
                end
            end
            if (gfx_valid) begin
                if (gfx_exp.size() == 0) begin
                    chk("unexpected_gfx_valid", 32'(gfx_dout), 32'hFFFFFFFF);
                end else begin
                    re = gfx_exp.pop_front();
                    chk("gfx_dout", 32'(gfx_dout), 32'(re.data));
                    chk("gfx_latency", 32'(cyc), 32'(ack_cyc + 2));
                end
            end
        end
        prev_req = port_req;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock_48);
    endtask

    task automatic exp_port(input logic [22:0] a, input logic [1:0] ds, input logic we, input logic [15:0] d);
        port_exp_t e;
        e.a = a; e.ds = ds; e.we = we; e.d = d;
        port_exp.push_back(e);
    endtask

    task automatic exp_rd(input bit is_cpu, input logic [15:0] data, input bit rel_ack, input int due);
        rd_exp_t e;
        e.data = data; e.rel_ack = rel_ack; e.due = due;
        if (is_cpu) cpu_exp.push_back(e);
        else        gfx_exp.push_back(e);
    endtask

    task automatic pulse_dl(input logic [23:0] a, input logic [7:0] d);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        tick();
        dl_wr = 1'b0;
    endtask

    task automatic pulse_rd(input bit do_cpu, input logic [15:0] ca, input bit do_gfx, input logic [15:0] ga);
        cpu_req = do_cpu; cpu_addr = ca;
        gfx_req = do_gfx; gfx_addr = ga;
        tick();
        cpu_req = 1'b0; gfx_req = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((port_exp.size() != 0 || cpu_exp.size() != 0 || gfx_exp.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 32'(n), 32'd0);
        tick(3);
    endtask

    initial begin
        int t0;
        mem[32'h00091A] = 16'hBEEF;
        mem[32'h008005] = 16'h1357;
        mem[32'h000008] = 16'h2468;
        mem[32'h000020] = 16'hA585;

        tick(3);
        chk("rst_port_req", 32'(port_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        chk("rst_gfx_valid", 32'(gfx_valid), 32'd0);
        chk("rst_overrun", 32'(dl_overrun), 32'd0);
        chk("rst_port_a", 32'(port_a), 32'd0);
        reset = 1'b0;
        tick(3);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Download byte write
        dl_active = 1'b1;
        t0 = n_tog;
        exp_port(23'h000001, 2'b10, 1'b1, 16'hA5A5);
        pulse_dl(24'h000003, 8'hA5);
        wait_quiet("dl_byte");
        chk("dl_one_toggle", 32'(n_tog - t0), 32'd1);
        chk("dl_no_overrun", 32'(dl_overrun), 32'd0);
        dl_active = 1'b0;
        tick(3);

        // CPU miss, then hit in the same word
        exp_port(23'h00091A, 2'b11, 1'b0, 16'h0000);
        exp_rd(1'b1, 16'h00BE, 1'b1, 0);
        pulse_rd(1'b1, 16'h1235, 1'b0, 16'h0000);
        wait_quiet("cpu_miss");
        t0 = n_tog;
        exp_rd(1'b1, 16'h00EF, 1'b0, cyc + 2);
        pulse_rd(1'b1, 16'h1234, 1'b0, 16'h0000);
        wait_quiet("cpu_hit");
        chk("hit_no_toggle", 32'(n_tog - t0), 32'd0);

        // Round-robin: last grant was CPU, so GFX goes first
        exp_port(23'h008005, 2'b11, 1'b0, 16'h0000);
        exp_port(23'h000008, 2'b11, 1'b0, 16'h0000);
        exp_rd(1'b0, 16'h1357, 1'b1, 0);
        exp_rd(1'b1, 16'h0068, 1'b1, 0);
        pulse_rd(1'b1, 16'h0010, 1'b1, 16'h0005);
        wait_quiet("round_robin");

        // GFX at the top of its offset range
        exp_port(23'h017FFF, 2'b11, 1'b0, 16'h0000);
        exp_rd(1'b0, 16'hDA5A, 1'b1, 0);
        pulse_rd(1'b0, 16'h0000, 1'b1, 16'hFFFF);
        wait_quiet("gfx_top");

        // Download overrun with a slow ack
        lat = 10;
        dl_active = 1'b1;
        t0 = n_tog;
        exp_port(23'h000080, 2'b01, 1'b1, 16'h3C3C);
        pulse_dl(24'h000100, 8'h3C);
        tick();
        pulse_dl(24'h000101, 8'h77);
        wait_quiet("dl_overrun");
        chk("overrun_set", 32'(dl_overrun), 32'd1);
        chk("overrun_one_write", 32'(n_tog - t0), 32'd1);
        dl_active = 1'b0;
        lat = 3;
        tick(3);
        chk("overrun_sticky", 32'(dl_overrun), 32'd1);

        // Reset in WAIT with the ack withheld
        model_en = 1'b0;
        exp_port(23'h008020, 2'b11, 1'b0, 16'h0000);
        pulse_rd(1'b0, 16'h0000, 1'b1, 16'h0020);
        tick(4);
        chk("midrst_req_hi", 32'(port_req), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(2);
        chk("midrst_req_cleared", 32'(port_req), 32'd0);
        chk("midrst_overrun_cleared", 32'(dl_overrun), 32'd0);
        reset = 1'b0;
        tick(5);
        ack_ovr_val = 1'b1;
        ack_ovr_en  = 1'b1;
        tick(4);
        chk("stale_ack_sync", 32'(busy), 32'd1);
        chk("stale_ack_no_toggle", 32'(port_req), 32'd0);
        ack_ovr_en = 1'b0;
        model_en   = 1'b1;
        tick(10);
        chk("sync_released", 32'(busy), 32'd0);
        chk("pending_lost", 32'(gfx_exp.size()), 32'd0);

        // Download gating and falling-edge cache invalidate
        exp_port(23'h000020, 2'b11, 1'b0, 16'h0000);
        exp_rd(1'b1, 16'h0085, 1'b1, 0);
        pulse_rd(1'b1, 16'h0040, 1'b0, 16'h0000);
        wait_quiet("gate_fill");
        dl_active = 1'b1;
        tick(2);
        t0 = n_tog;
        exp_rd(1'b1, 16'h005A, 1'b1, 0);
        pulse_rd(1'b1, 16'h0041, 1'b0, 16'h0000);
        tick(8);
        chk("gate_no_toggle", 32'(n_tog - t0), 32'd0);
        chk("gate_held", 32'(cpu_exp.size()), 32'd1);
        mem[32'h000020] = 16'h5AC3;
        exp_port(23'h000020, 2'b11, 1'b0, 16'h0000);
        dl_active = 1'b0;
        wait_quiet("gate_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
